nvdla_cmac_cell_array: RTL and testbench
========================================

Name: nvdla_cmac_cell_array

Overview:
- Parametrised convolution MAC cell array: successor to the fixed-size CMAC inside partition M.
- Takes sc2mac weight and data beats and holds double-buffered weights per output lane.
- Computes masked signed dot products over a configurable-depth pipeline and emits mac2accu beats to the accumulator.
- Adds stripe-synchronised weight bank swap and an activity-based SLCG enable with override.

Parameters:
- ATOMC, 8, input channels per beat (power of 2, 2..64)
- ATOMK_HALF, 4, output lanes (1..32)
- BPE, 8, signed element width
- PIPE_DEPTH, 3, data-beat to mac2accu_pvld latency in cycles (>=1)
- PD_W, 9, sideband width passed data -> accu
- STRIPE_ST_BIT, 8, bit of sc2mac_dat_pd that triggers bank swap
- IDLE_CYCLES, 16, idle cycles before slcg_en drops (>=1)

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  asynchronous active-high reset
- sc2mac_wt_pvld  in  1  weight beat valid
- sc2mac_wt_mask  in  ATOMC  per-element weight nonzero mask
- sc2mac_wt_data  in  ATOMC*BPE  weights, element i at [i*BPE +: BPE]
- sc2mac_wt_sel  in  ATOMK_HALF  lanes whose shadow bank is written
- sc2mac_dat_pvld  in  1  data beat valid
- sc2mac_dat_mask  in  ATOMC  per-element data mask
- sc2mac_dat_data  in  ATOMC*BPE  feature data
- sc2mac_dat_pd  in  PD_W  sideband
- cfg_mode  in  1  quasi-static mode, forwarded
- clk_ovr_on  in  1  force slcg_en
- mac2accu_pvld  out  1  result valid
- mac2accu_mask  out  ATOMK_HALF  lanes carrying valid results
- mac2accu_mode  out  1  cfg_mode sampled with the beat
- mac2accu_data  out  ATOMK_HALF*RW  results, RW = 2*BPE + log2(ATOMC)
- mac2accu_pd  out  PD_W  delayed sideband
- slcg_en  out  1  clock-enable request

Behaviour:
- Reset (async assert, sync release): all outputs 0 except slcg_en=1; shadow_ld[k]=0, active_vld[k]=0, pipeline valids 0, idle counter = IDLE_CYCLES. Reset mid-beat drops in-flight beats; nothing emitted after release.
- Weight write, when wt_pvld: for each k with wt_sel[k]=1: shadow_w[k] <= data, shadow_m[k] <= mask, shadow_ld[k] <= 1. If wt_sel=0, no effect.
- Swap, when dat_pvld && pd[STRIPE_ST_BIT]: for each k with shadow_ld[k], active <= shadow, active_vld[k] <= 1, shadow_ld[k] <= 0. The beat computes using the newly swapped weights (swap combinational into stage 0).
- Weight write to lane k in the same cycle as a swap: the swap uses the old shadow contents; the new write lands in shadow; shadow_ld[k] ends at 1.
- Compute, lane k: sum over i of (dat_mask[i] & act_m[k][i]) ? signed(d[i])*signed(w[k][i]) : 0. Full-width signed result, no saturation. Sign-extend into RW bits; never wraps.
- Lanes with active_vld[k]=0 output data 0 and mask bit 0.
- Pipeline: beat accepted in cycle t appears at t+PIPE_DEPTH. pd, mode and mask travel with it.
- Throughput: 1 beat/cycle, no backpressure. Back-to-back beats are emitted back-to-back.
- When pvld=0, data/pd/mask hold their last values; mode is don't-care.
- slcg_en: counter reloads to IDLE_CYCLES on any wt_pvld, dat_pvld or in-flight beat. Otherwise it decrements, saturating at 0. slcg_en = clk_ovr_on | (counter != 0).

Decomposition:
- Package nvdla_cmac_pkg holds: RW calculation function, log2 helper, and lane data slicing localparams.
- Sub-module nvdla_cmac_lane: one lane's shadow/active banks, masked multiply and adder tree pipelined to PIPE_DEPTH.
- Top instantiates ATOMK_HALF lanes, the shared valid/pd/mode delay line, and the SLCG counter.

Test Plan:
- Load, swap, compute (defaults): wt_sel=4'b0001, w=all 2; then data all 3 with pd[8]=1, masks all 1 -> 3 cycles later: pvld=1, mask=4'b0001, lane0=48, lanes1-3=0.
- Signed extremes: w=-128, d=-128, all 8 elements -> lane = 131072 (RW=19, exact). With d=127, w=-128 -> -130048.
- Masking: dat_mask=8'h0F, wt_mask=8'h3C, w=d=1 -> lane=2 (elements 2,3 only).
- Same-cycle write and swap to lane 1: old shadow w=1 is used for the beat; new w=5 is used at the next pd[8]=1 beat. Data all 1 -> results 8, then 40.
- Back-to-back: 5 consecutive beats with pd=0..4 -> pvld high for exactly 5 cycles, pd 0..4 in order. Reset asserted mid-stream -> pvld=0 immediately, nothing emitted after release.
- SLCG: idle after the last beat -> slcg_en falls exactly IDLE_CYCLES cycles after the pipeline drains. clk_ovr_on=1 -> slcg_en stays 1.

Source files
------------

// File: rtl/nvdla_cmac_pkg.sv
// Shared sizing helpers for the CMAC cell array and its lanes.
package nvdla_cmac_pkg;

  // Ceiling log2 for elaboration-time sizing (n >= 1).
  function automatic int cmac_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Result width of one lane: full product width plus growth of the ATOMC-term sum.
  function automatic int cmac_rw(input int bpe, input int atomc);
    return 2 * bpe + cmac_log2(atomc);
  endfunction

  // Low bit of lane k inside the packed mac2accu_data bus.
  function automatic int cmac_lane_lo(input int k, input int rw);
    return k * rw;
  endfunction

  localparam int DEF_ATOMC = 8;
  localparam int DEF_BPE   = 8;
  localparam int DEF_RW    = 2 * DEF_BPE + 3;

endpackage

// File: rtl/nvdla_cmac_lane.sv
// One output lane: double-buffered weights, masked signed dot product and
// a valid-gated result delay line of PIPE_DEPTH registers.
module nvdla_cmac_lane
  import nvdla_cmac_pkg::*;
#(
  parameter int ATOMC      = DEF_ATOMC,
  parameter int BPE        = DEF_BPE,
  parameter int PIPE_DEPTH = 3,
  parameter int RW         = cmac_rw(DEF_BPE, DEF_ATOMC)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wt_we_i,
  input  logic [ATOMC-1:0]      wt_mask_i,
  input  logic [ATOMC*BPE-1:0]  wt_data_i,
  input  logic                  swap_i,
  input  logic [PIPE_DEPTH-1:0] ld_i,
  input  logic [ATOMC-1:0]      dat_mask_i,
  input  logic [ATOMC*BPE-1:0]  dat_data_i,
  output logic                  lane_vld_o,
  output logic [RW-1:0]         res_o
);

  logic [ATOMC*BPE-1:0]        shadow_w_q, active_w_q, eff_w;
  logic [ATOMC-1:0]            shadow_m_q, active_m_q, eff_m;
  logic                        shadow_ld_q, shadow_ld_d, active_vld_q;
  logic                        take_shadow;
  logic signed [RW-1:0]        sum, stage0;
  logic [PIPE_DEPTH-1:0][RW-1:0] res_q;

  // Sign-extended product of one data/weight element pair.
  function automatic logic signed [RW-1:0] mac_term(input logic signed [BPE-1:0] a,
                                                     input logic signed [BPE-1:0] b);
    logic signed [2*BPE-1:0] p;
    p = a * b;
    return {{(RW-2*BPE){p[2*BPE-1]}}, p};
  endfunction

  // A swapping beat sees the shadow bank directly, so it computes with the new weights.
  assign take_shadow = swap_i & shadow_ld_q;
  assign eff_w       = take_shadow ? shadow_w_q : active_w_q;
  assign eff_m       = take_shadow ? shadow_m_q : active_m_q;
  assign lane_vld_o  = active_vld_q | take_shadow;

  // A write in the swap cycle wins: it re-arms the shadow after the old contents move over.
  assign shadow_ld_d = wt_we_i ? 1'b1 : (take_shadow ? 1'b0 : shadow_ld_q);

  // Weight bank storage; qualified by the control flags so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (wt_we_i) begin
      shadow_w_q <= wt_data_i;
      shadow_m_q <= wt_mask_i;
    end
    if (take_shadow) begin
      active_w_q <= shadow_w_q;
      active_m_q <= shadow_m_q;
    end
  end

  // Bank status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_ld_q  <= 1'b0;
      active_vld_q <= 1'b0;
    end else begin
      shadow_ld_q <= shadow_ld_d;
      if (take_shadow) active_vld_q <= 1'b1;
    end
  end

  // Masked dot product; an unloaded lane contributes zero.
  always_comb begin
    sum = '0;
    for (int i = 0; i < ATOMC; i++) begin
      if (dat_mask_i[i] & eff_m[i])
        sum = sum + mac_term(dat_data_i[i*BPE +: BPE], eff_w[i*BPE +: BPE]);
    end
    stage0 = lane_vld_o ? sum : '0;
  end

  // Result delay line; each stage only moves with a valid beat so the output holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q <= '0;
    end else begin
      if (ld_i[0]) res_q[0] <= stage0;
      for (int j = 1; j < PIPE_DEPTH; j++) begin
        if (ld_i[j]) res_q[j] <= res_q[j-1];
      end
    end
  end

  assign res_o = res_q[PIPE_DEPTH-1];

endmodule

// File: rtl/nvdla_cmac_cell_array.sv
// Parametrised CMAC cell array: ATOMK_HALF lanes, shared valid/pd/mode/mask
// delay line, and an activity-driven clock-enable request.
module nvdla_cmac_cell_array
  import nvdla_cmac_pkg::*;
#(
  parameter int ATOMC         = 8,
  parameter int ATOMK_HALF    = 4,
  parameter int BPE           = 8,
  parameter int PIPE_DEPTH    = 3,
  parameter int PD_W          = 9,
  parameter int STRIPE_ST_BIT = 8,
  parameter int IDLE_CYCLES   = 16
) (
  input  logic                                        nvdla_core_clk,
  input  logic                                        nvdla_core_rst,
  input  logic                                        sc2mac_wt_pvld,
  input  logic [ATOMC-1:0]                            sc2mac_wt_mask,
  input  logic [ATOMC*BPE-1:0]                        sc2mac_wt_data,
  input  logic [ATOMK_HALF-1:0]                       sc2mac_wt_sel,
  input  logic                                        sc2mac_dat_pvld,
  input  logic [ATOMC-1:0]                            sc2mac_dat_mask,
  input  logic [ATOMC*BPE-1:0]                        sc2mac_dat_data,
  input  logic [PD_W-1:0]                             sc2mac_dat_pd,
  input  logic                                        cfg_mode,
  input  logic                                        clk_ovr_on,
  output logic                                        mac2accu_pvld,
  output logic [ATOMK_HALF-1:0]                       mac2accu_mask,
  output logic                                        mac2accu_mode,
  output logic [ATOMK_HALF*cmac_rw(BPE, ATOMC)-1:0]   mac2accu_data,
  output logic [PD_W-1:0]                             mac2accu_pd,
  output logic                                        slcg_en
);

  localparam int RW    = cmac_rw(BPE, ATOMC);
  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);

  logic                            swap;
  logic [PIPE_DEPTH-1:0]           vld_q, ld;
  logic [PIPE_DEPTH-1:0][PD_W-1:0] pd_q;
  logic [PIPE_DEPTH-1:0]           mode_q;
  logic [PIPE_DEPTH-1:0][ATOMK_HALF-1:0] mask_q;
  logic [ATOMK_HALF-1:0]           lane_vld;
  logic [RW-1:0]                   lane_res [ATOMK_HALF];
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  assign swap = sc2mac_dat_pvld & sc2mac_dat_pd[STRIPE_ST_BIT];

  // Per-stage load enables: stage j advances when the beat in front of it is valid.
  always_comb begin
    ld    = '0;
    ld[0] = sc2mac_dat_pvld;
    for (int j = 1; j < PIPE_DEPTH; j++) ld[j] = vld_q[j-1];
  end

  for (genvar k = 0; k < ATOMK_HALF; k++) begin : g_lane
    nvdla_cmac_lane #(
      .ATOMC      (ATOMC),
      .BPE        (BPE),
      .PIPE_DEPTH (PIPE_DEPTH),
      .RW         (RW)
    ) u_lane (
      .clk_i      (nvdla_core_clk),
      .rst_i      (nvdla_core_rst),
      .wt_we_i    (sc2mac_wt_pvld & sc2mac_wt_sel[k]),
      .wt_mask_i  (sc2mac_wt_mask),
      .wt_data_i  (sc2mac_wt_data),
      .swap_i     (swap),
      .ld_i       (ld),
      .dat_mask_i (sc2mac_dat_mask),
      .dat_data_i (sc2mac_dat_data),
      .lane_vld_o (lane_vld[k]),
      .res_o      (lane_res[k])
    );
    assign mac2accu_data[cmac_lane_lo(k, RW) +: RW] = lane_res[k];
  end

  // Shared sideband delay line; reset drops every in-flight beat.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      vld_q  <= '0;
      pd_q   <= '0;
      mode_q <= '0;
      mask_q <= '0;
    end else begin
      vld_q[0] <= sc2mac_dat_pvld;
      if (sc2mac_dat_pvld) begin
        pd_q[0]   <= sc2mac_dat_pd;
        mode_q[0] <= cfg_mode;
        mask_q[0] <= lane_vld;
      end
      for (int j = 1; j < PIPE_DEPTH; j++) begin
        vld_q[j] <= vld_q[j-1];
        if (vld_q[j-1]) begin
          pd_q[j]   <= pd_q[j-1];
          mode_q[j] <= mode_q[j-1];
          mask_q[j] <= mask_q[j-1];
        end
      end
    end
  end

  assign mac2accu_pvld = vld_q[PIPE_DEPTH-1];
  assign mac2accu_pd   = pd_q[PIPE_DEPTH-1];
  assign mac2accu_mode = mode_q[PIPE_DEPTH-1];
  assign mac2accu_mask = mask_q[PIPE_DEPTH-1];

  // Idle counter: any input beat or in-flight beat reloads, otherwise count down to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (sc2mac_wt_pvld | sc2mac_dat_pvld | (|vld_q)) cnt_d = CNT_W'(IDLE_CYCLES);
    else if (cnt_q != '0)                             cnt_d = cnt_q - 1'b1;
  end

  // Idle counter register.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) cnt_q <= CNT_W'(IDLE_CYCLES);
    else                cnt_q <= cnt_d;
  end

  assign slcg_en = clk_ovr_on | (cnt_q != '0);

endmodule

// File: tb/tb_nvdla_cmac_cell_array.sv
// Directed bench for nvdla_cmac_cell_array at default parameters.
module tb_nvdla_cmac_cell_array;
  import nvdla_cmac_pkg::*;

  localparam int ATOMC = 8, AK = 4, BPE = 8, PD_W = 9, RW = 19;

  logic              clk = 1'b0, rst = 1'b1;
  logic              wt_pvld = 0, dat_pvld = 0, cfg_mode = 0, clk_ovr_on = 0;
  logic [ATOMC-1:0]  wt_mask = 0, dat_mask = 0;
  logic [ATOMC*BPE-1:0] wt_data = 0, dat_data = 0;
  logic [AK-1:0]     wt_sel = 0;
  logic [PD_W-1:0]   dat_pd = 0;
  logic              o_pvld, o_mode, o_slcg;
  logic [AK-1:0]     o_mask;
  logic [AK*RW-1:0]  o_data;
  logic [PD_W-1:0]   o_pd;

  int checks = 0, failures = 0;

  nvdla_cmac_cell_array dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rst  (rst),
    .sc2mac_wt_pvld  (wt_pvld),
    .sc2mac_wt_mask  (wt_mask),
    .sc2mac_wt_data  (wt_data),
    .sc2mac_wt_sel   (wt_sel),
    .sc2mac_dat_pvld (dat_pvld),
    .sc2mac_dat_mask (dat_mask),
    .sc2mac_dat_data (dat_data),
    .sc2mac_dat_pd   (dat_pd),
    .cfg_mode        (cfg_mode),
    .clk_ovr_on      (clk_ovr_on),
    .mac2accu_pvld   (o_pvld),
    .mac2accu_mask   (o_mask),
    .mac2accu_mode   (o_mode),
    .mac2accu_data   (o_data),
    .mac2accu_pd     (o_pd),
    .slcg_en         (o_slcg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AK-1:0]   sel;
    int              w;
    logic [7:0]      wm;
    int              d;
    logic [7:0]      dm;
    logic [PD_W-1:0] pd;
    logic            mode;
    logic [AK-1:0]   exp_mask;
    int              exp_lane [AK];
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int lane(input int k);
    logic signed [RW-1:0] s;
    s = o_data[k*RW +: RW];
    return int'(s);
  endfunction

  function automatic logic [ATOMC*BPE-1:0] fill(input int v);
    logic [ATOMC*BPE-1:0] r;
    logic [7:0] b;
    b = v[7:0];
    for (int i = 0; i < ATOMC; i++) r[i*BPE +: BPE] = b;
    return r;
  endfunction

  task automatic set_wt(input logic [AK-1:0] sel, input int w, input logic [7:0] wm);
    wt_pvld = 1; wt_sel = sel; wt_data = fill(w); wt_mask = wm;
  endtask

  task automatic set_dat(input int d, input logic [7:0] dm, input logic [PD_W-1:0] pd,
                         input logic mode);
    dat_pvld = 1; dat_data = fill(d); dat_mask = dm; dat_pd = pd; cfg_mode = mode;
  endtask

  initial begin
    int n, first, last, idx, seen;
    vt[0] = '{4'b0001, 2,    8'hFF, 3,    8'hFF, 9'h100, 1'b0, 4'b0001, '{48, 0, 0, 0}};
    vt[1] = '{4'b0010, -128, 8'hFF, -128, 8'hFF, 9'h101, 1'b0, 4'b0011, '{-2048, 131072, 0, 0}};
    vt[2] = '{4'b0100, -128, 8'hFF, 127,  8'hFF, 9'h102, 1'b0, 4'b0111, '{2032, -130048, -130048, 0}};
    vt[3] = '{4'b1000, 1,    8'h3C, 1,    8'h0F, 9'h103, 1'b0, 4'b1111, '{8, -512, -512, 2}};
    vt[4] = '{4'b0000, 99,   8'hFF, 1,    8'hFF, 9'h005, 1'b1, 4'b1111, '{16, -1024, -1024, 4}};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pvld", int'(o_pvld), 0);
    chk("rst_mask", int'(o_mask), 0);
    chk("rst_data", int'(o_data != '0), 0);
    chk("rst_pd",   int'(o_pd), 0);
    chk("rst_mode", int'(o_mode), 0);
    chk("rst_slcg", int'(o_slcg), 1);
    rst = 0;
    @(negedge clk);

    // Table: load, swap, compute, check after PIPE_DEPTH cycles
    for (int v = 0; v < 5; v++) begin
      set_wt(vt[v].sel, vt[v].w, vt[v].wm);
      @(negedge clk);
      wt_pvld = 0;
      set_dat(vt[v].d, vt[v].dm, vt[v].pd, vt[v].mode);
      @(negedge clk);
      dat_pvld = 0;
      chk($sformatf("v%0d_pvld_early", v), int'(o_pvld), 0);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_pvld", v), int'(o_pvld), 1);
      chk($sformatf("v%0d_mask", v), int'(o_mask), int'(vt[v].exp_mask));
      chk($sformatf("v%0d_pd", v), int'(o_pd), int'(vt[v].pd));
      chk($sformatf("v%0d_mode", v), int'(o_mode), int'(vt[v].mode));
      for (int k = 0; k < AK; k++)
        chk($sformatf("v%0d_lane%0d", v, k), lane(k), vt[v].exp_lane[k]);
      @(negedge clk);
      chk($sformatf("v%0d_pvld_pulse", v), int'(o_pvld), 0);
      chk($sformatf("v%0d_hold_lane0", v), lane(0), vt[v].exp_lane[0]);
    end

    // Same-cycle write and swap on lane 1
    set_wt(4'b0010, 1, 8'hFF);
    @(negedge clk);
    set_wt(4'b0010, 5, 8'hFF);
    set_dat(1, 8'hFF, 9'h100, 1'b0);
    @(negedge clk);
    wt_pvld = 0;
    set_dat(1, 8'hFF, 9'h100, 1'b0);
    @(negedge clk);
    dat_pvld = 0;
    @(negedge clk);
    chk("wsw_old_pvld", int'(o_pvld), 1);
    chk("wsw_old_lane1", lane(1), 8);
    chk("wsw_old_lane0", lane(0), 16);
    @(negedge clk);
    chk("wsw_new_pvld", int'(o_pvld), 1);
    chk("wsw_new_lane1", lane(1), 40);
    chk("wsw_new_lane3", lane(3), 4);
    repeat (2) @(negedge clk);

    // Back-to-back beats
    first = -1; last = -1; idx = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_pvld) begin
        chk($sformatf("b2b_pd%0d", idx), int'(o_pd), idx);
        if (first < 0) first = c;
        last = c;
        idx++;
      end
      if (c < 5) set_dat(1, 8'hFF, PD_W'(c), 1'b0);
      else dat_pvld = 0;
    end
    chk("b2b_count", idx, 5);
    chk("b2b_contig", last - first, 4);

    // Reset mid-stream
    @(negedge clk); set_dat(1, 8'hFF, 9'h007, 1'b0);
    @(negedge clk); set_dat(1, 8'hFF, 9'h008, 1'b0);
    @(negedge clk); dat_pvld = 0; rst = 1;
    #1;
    chk("mid_rst_pvld", int'(o_pvld), 0);
    chk("mid_rst_data", int'(o_data != '0), 0);
    chk("mid_rst_mask", int'(o_mask), 0);
    chk("mid_rst_slcg", int'(o_slcg), 1);
    repeat (2) @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_pvld) seen++;
    end
    chk("mid_rst_no_emit", seen, 0);

    // SLCG idle countdown after drain
    set_dat(1, 8'hFF, 9'h000, 1'b0);
    @(negedge clk);
    dat_pvld = 0;
    n = 0;
    while (!o_pvld && n < 10) begin @(negedge clk); n++; end
    chk("slcg_pvld_rise", int'(o_pvld), 1);
    n = 0;
    while (o_pvld && n < 10) begin @(negedge clk); n++; end
    chk("slcg_pvld_fall", int'(o_pvld), 0);
    n = 0;
    while (o_slcg && n < 100) begin @(negedge clk); n++; end
    chk("slcg_idle_cycles", n, 16);
    chk("slcg_low", int'(o_slcg), 0);

    // Override
    clk_ovr_on = 1;
    #1;
    chk("ovr_immediate", int'(o_slcg), 1);
    repeat (20) @(negedge clk);
    chk("ovr_held", int'(o_slcg), 1);
    clk_ovr_on = 0;
    #1;
    chk("ovr_release", int'(o_slcg), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
